alarm_multi_snooze: RTL and testbench
=====================================

// Module: alarm_multi_snooze
// PURPOSE
//   N-channel alarm controller with snooze; parametrised successor of the single-channel alarm-length block.
//   Each channel compares cur_sec to its own target, rings for a selectable length (15/30/45/60 s),
//   and accepts global off/snooze buttons. Per-channel snooze re-arms ringing after SNOOZE_SEC, up to MAX_SNOOZE times.
//   Sits between the timekeeping counter and the buzzer/LED driver; alarming drives the buzzer directly.
// PARAMETERS
//   N_CH        4       number of alarm channels (1..8)
//   SEC_W       17      width of second-of-day values
//   SNOOZE_SEC  300     snooze interval in seconds (< 2**9)
//   MAX_SNOOZE  3       snoozes allowed per trigger (0 = snooze ignored)
// PORTS
//   sec_clk     in   1          1 Hz clock; cur_sec advances by one per edge
//   rst         in   1          synchronous active-high reset
//   cur_sec     in   SEC_W      current second of day, 0..86399
//   tar_sec     in   N_CH*SEC_W target second, channel i at [i*SEC_W +: SEC_W]
//   len_s       in   2*N_CH     ring length select, channel i at [2i +: 2]
//   en          in   N_CH       per-channel enable
//   off         in   1          stop all ringing channels (level, sampled per edge)
//   snooze      in   1          snooze all ringing channels (level, sampled per edge)
//   alarming    out  1          OR of ring_vec
//   ring_vec    out  N_CH       channel i in RINGING
//   snz_vec     out  N_CH       channel i in SNOOZED
//   active_id   out  3          lowest index with ring_vec set; 0 when none
// BEHAVIOUR
//   Reset: every channel IDLE, snooze count 0, timers 0; alarming, ring_vec, snz_vec, active_id all 0.
//   All outputs registered (one-edge latency from the causing input). Per-channel FSM, priority top-down:
//   any state, en[i]=0          -> IDLE, count cleared (disable mid-ring stops immediately).
//   IDLE:     cur_sec==tar_sec[i] -> RINGING, timer <= len(len_s[i]); tar_sec >= 86400 never matches.
//   RINGING:  off               -> DONE (off wins over simultaneous snooze).
//             snooze & count<MAX_SNOOZE -> SNOOZED, timer <= SNOOZE_SEC-1, count++.
//             snooze & count==MAX_SNOOZE -> ignored, stays RINGING.
//             timer==0          -> DONE (unanswered alarm times out), else timer--.
//   SNOOZED:  off               -> DONE (cancels pending snooze).
//             timer==0          -> RINGING, timer <= len, else timer--; snooze ignored here.
//   DONE:     cur_sec!=tar_sec[i] -> IDLE, count cleared; blocks re-trigger within the same second.
//   Ring length: RINGING holds len+1 edges (e.g. len_s=0 -> 16 ring edges incl. entry edge).
//   Timers are 9 bits; len values 15/30/45/60 from package. Midnight wrap needs no special case: timers
//   are relative, so a 23:59:50 alarm rings across 00:00:00 unchanged.
//   off/snooze act on every channel in the qualifying state at that edge; channels triggering on that
//   same edge enter RINGING and are not affected until the next edge.
//   cur_sec jump (time set) while RINGING/SNOOZED: no effect on timers; only equality gates IDLE exit.
//   active_id: priority encode of next ring_vec, lowest index wins.
// STRUCTURE
//   Package alarm_pkg: state encoding (IDLE=0,RINGING=1,SNOOZED=2,DONE=3), LEN_TABLE {15,30,45,60},
//   DAY_SEC=86400, TIMER_W=9.
//   Sub-module alarm_channel: one FSM + timer + snooze counter; top generates N_CH instances, ORs
//   ring_vec into alarming and priority-encodes active_id.
// TESTING
//   1. ch0 tar=100,len_s=0,en=1; run to cur=100 -> ring_vec[0]=1 at cur 100..115, 0 from 116, DONE->IDLE.
//   2. ch1 ringing, snooze at edge k -> snz_vec[1]=1 for 300 edges, then ring_vec[1]=1 again; 4th snooze
//      (MAX=3) ignored, ringing continues to timeout.
//   3. ch0 and ch2 same tar; off+snooze together on 3rd ring edge -> both DONE, alarming=0 next edge.
//   4. tar=86390,len_s=1, cur wraps 86399->0 -> ringing continuous, ends at cur=20 (31 ring edges).
//   5. en[0] dropped mid-ring -> ring_vec[0]=0 next edge; rst asserted in SNOOZED -> all outputs 0,
//      no re-ring after snooze interval.
//   6. ch1 and ch3 ringing -> active_id=1; ch1 off... (global) both stop; ch3 only -> active_id=3.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-channel alarm controller.
//   ch_state_e    : per-channel FSM encoding (fixed values, visible to debug tooling)
//   TIMER_W       : width of the ring / snooze down-counters
//   DAY_SEC       : seconds per day; targets at or above this never trigger
//   LEN_TABLE     : ring length in seconds, indexed by the 2-bit length select
//   ring_len()    : length-select to timer load value
//   lowest_index(): priority encoder, lowest set bit wins, 0 when none set
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnoozed = 2'd2,
    StDone    = 2'd3
  } ch_state_e;

  localparam int unsigned TIMER_W = 9;
  localparam int unsigned DAY_SEC = 86400;

  localparam logic [TIMER_W-1:0] LEN_TABLE [4] = '{9'd15, 9'd30, 9'd45, 9'd60};

  function automatic logic [TIMER_W-1:0] ring_len(input logic [1:0] sel);
    return LEN_TABLE[sel];
  endfunction

  function automatic logic [2:0] lowest_index(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: FSM, shared ring/snooze down-counter and snooze counter.
// Ports:
//   sec_clk_i   1 Hz clock
//   rst_i       synchronous active-high reset
//   cur_sec_i   current second of day
//   tar_sec_i   this channel's target second
//   len_sel_i   ring length select (15/30/45/60 s)
//   en_i        channel enable; low forces IDLE immediately
//   off_i       global stop button (level)
//   snooze_i    global snooze button (level)
//   ring_o      channel is RINGING (registered)
//   snz_o       channel is SNOOZED (registered)
//   ring_next_o channel will be RINGING after this edge (feeds registered top outputs)
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned SecW      = 17,
  parameter int unsigned SnoozeSec = 300,
  parameter int unsigned MaxSnooze = 3
) (
  input  logic            sec_clk_i,
  input  logic            rst_i,
  input  logic [SecW-1:0] cur_sec_i,
  input  logic [SecW-1:0] tar_sec_i,
  input  logic [1:0]      len_sel_i,
  input  logic            en_i,
  input  logic            off_i,
  input  logic            snooze_i,
  output logic            ring_o,
  output logic            snz_o,
  output logic            ring_next_o
);

  // A zero snooze budget still needs a 1-bit counter; comparing it against 0 disables snooze.
  localparam int unsigned CntW = (MaxSnooze > 0) ? $clog2(MaxSnooze + 1) : 1;
  localparam logic [CntW-1:0]    CntMax     = CntW'(MaxSnooze);
  localparam logic [TIMER_W-1:0] SnoozeLoad = TIMER_W'(SnoozeSec - 1);

  ch_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               match;

  // Out-of-range targets are parked values and must never fire, even if cur_sec is forced there.
  assign match = (cur_sec_i == tar_sec_i) && (32'(tar_sec_i) < DAY_SEC);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = StIdle;
      timer_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match) begin
            state_d = StRinging;
            timer_d = ring_len(len_sel_i);
          end
        end
        StRinging: begin
          if (off_i) begin
            state_d = StDone;
          end else if (snooze_i && (cnt_q < CntMax)) begin
            state_d = StSnoozed;
            timer_d = SnoozeLoad;
            cnt_d   = cnt_q + 1'b1;
          end else if (timer_q == '0) begin
            state_d = StDone;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        StSnoozed: begin
          if (off_i) begin
            state_d = StDone;
          end else if (timer_q == '0) begin
            state_d = StRinging;
            timer_d = ring_len(len_sel_i);
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        StDone: begin
          // Hold here while still on the target second so a stopped alarm cannot re-fire.
          if (cur_sec_i != tar_sec_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sec_clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ring_o      = (state_q == StRinging);
  assign snz_o       = (state_q == StSnoozed);
  assign ring_next_o = (state_d == StRinging);

endmodule

// File: rtl/alarm_multi_snooze.sv
// N-channel alarm controller with per-channel snooze, between the timekeeping counter and the
// buzzer/LED driver.
// Ports:
//   sec_clk    1 Hz clock
//   rst        synchronous active-high reset
//   cur_sec    current second of day
//   tar_sec    packed targets, channel i at [i*SEC_W +: SEC_W]
//   len_s      packed ring length selects, channel i at [2i +: 2]
//   en         per-channel enable
//   off        stop every ringing/snoozed channel
//   snooze     snooze every ringing channel
//   alarming   buzzer drive, OR of ring_vec (registered)
//   ring_vec   per-channel RINGING
//   snz_vec    per-channel SNOOZED
//   active_id  lowest ringing channel index, 0 when none (registered)
module alarm_multi_snooze
  import alarm_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SEC_W      = 17,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                  sec_clk,
  input  logic                  rst,
  input  logic [SEC_W-1:0]      cur_sec,
  input  logic [N_CH*SEC_W-1:0] tar_sec,
  input  logic [2*N_CH-1:0]     len_s,
  input  logic [N_CH-1:0]       en,
  input  logic                  off,
  input  logic                  snooze,
  output logic                  alarming,
  output logic [N_CH-1:0]       ring_vec,
  output logic [N_CH-1:0]       snz_vec,
  output logic [2:0]            active_id
);

  logic [N_CH-1:0] ring_next;
  logic            alarming_q;
  logic [2:0]      active_id_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    alarm_channel #(
      .SecW      (SEC_W),
      .SnoozeSec (SNOOZE_SEC),
      .MaxSnooze (MAX_SNOOZE)
    ) u_ch (
      .sec_clk_i   (sec_clk),
      .rst_i       (rst),
      .cur_sec_i   (cur_sec),
      .tar_sec_i   (tar_sec[i*SEC_W +: SEC_W]),
      .len_sel_i   (len_s[2*i +: 2]),
      .en_i        (en[i]),
      .off_i       (off),
      .snooze_i    (snooze),
      .ring_o      (ring_vec[i]),
      .snz_o       (snz_vec[i]),
      .ring_next_o (ring_next[i])
    );
  end

  // Derived from next-state so these flops line up with ring_vec and never glitch the buzzer.
  always_ff @(posedge sec_clk) begin
    if (rst) begin
      alarming_q  <= 1'b0;
      active_id_q <= 3'd0;
    end else begin
      alarming_q  <= |ring_next;
      active_id_q <= lowest_index(8'(ring_next));
    end
  end

  assign alarming  = alarming_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_alarm_multi_snooze.sv
// Directed bench for alarm_multi_snooze: each step pushes the expected outputs to a scoreboard,
// clocks once, then pops and compares against the DUT.
module tb_alarm_multi_snooze;

  localparam int N = 4;
  localparam int W = 17;

  logic           sec_clk = 1'b0;
  logic           rst;
  logic [W-1:0]   cur_sec;
  logic [N*W-1:0] tar_sec;
  logic [2*N-1:0] len_s;
  logic [N-1:0]   en;
  logic           off;
  logic           snooze;
  logic           alarming;
  logic [N-1:0]   ring_vec;
  logic [N-1:0]   snz_vec;
  logic [2:0]     active_id;

  alarm_multi_snooze #(
    .N_CH       (N),
    .SEC_W      (W),
    .SNOOZE_SEC (300),
    .MAX_SNOOZE (3)
  ) dut (
    .sec_clk   (sec_clk),
    .rst       (rst),
    .cur_sec   (cur_sec),
    .tar_sec   (tar_sec),
    .len_s     (len_s),
    .en        (en),
    .off       (off),
    .snooze    (snooze),
    .alarming  (alarming),
    .ring_vec  (ring_vec),
    .snz_vec   (snz_vec),
    .active_id (active_id)
  );

  always #5 sec_clk = ~sec_clk;

  typedef struct {
    string      tag;
    logic [3:0] ring;
    logic [3:0] snz;
    logic       alarm;
    logic [2:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  function automatic logic [2:0] exp_id(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic set_tar(input int ch, input int v);
    tar_sec[ch*W +: W] = W'(v);
  endtask

  task automatic set_len(input int ch, input logic [1:0] v);
    len_s[2*ch +: 2] = v;
  endtask

  // One sec_clk edge; cur advances afterwards unless adv is 0 (time-set style steps).
  task automatic step(input bit adv, input string tag, input logic [3:0] ring,
                      input logic [3:0] snz);
    exp_t e;
    exp_t got;
    cur_sec = W'(cur);
    e.tag   = tag;
    e.ring  = ring;
    e.snz   = snz;
    e.alarm = |ring;
    e.id    = exp_id(ring);
    sb.push_back(e);
    @(posedge sec_clk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (ring_vec === got.ring) else begin
      errors++;
      $error("FAIL %s cur=%0d ring_vec got %b expected %b", got.tag, cur, ring_vec, got.ring);
    end
    checks++;
    assert (snz_vec === got.snz) else begin
      errors++;
      $error("FAIL %s cur=%0d snz_vec got %b expected %b", got.tag, cur, snz_vec, got.snz);
    end
    checks++;
    assert (alarming === got.alarm) else begin
      errors++;
      $error("FAIL %s cur=%0d alarming got %b expected %b", got.tag, cur, alarming, got.alarm);
    end
    checks++;
    assert (active_id === got.id) else begin
      errors++;
      $error("FAIL %s cur=%0d active_id got %0d expected %0d", got.tag, cur, active_id, got.id);
    end
    if (adv) cur = (cur + 1) % 86400;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, "reset", 4'b0000, 4'b0000);
    step(1'b0, "reset", 4'b0000, 4'b0000);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    en      = '0;
    off     = 1'b0;
    snooze  = 1'b0;
    len_s   = '0;
    cur_sec = '0;
    for (int c = 0; c < N; c++) set_tar(c, 131071);

    // Basic ring: 16 ring edges for len_s=0, then DONE -> IDLE.
    do_reset();
    set_tar(0, 100);
    set_len(0, 2'd0);
    en  = 4'b0001;
    cur = 98;
    step(1'b1, "t1 pre", 4'b0000, 4'b0000);
    step(1'b1, "t1 pre", 4'b0000, 4'b0000);
    for (int k = 0; k < 16; k++) step(1'b1, "t1 ring", 4'b0001, 4'b0000);
    step(1'b1, "t1 end", 4'b0000, 4'b0000);
    step(1'b1, "t1 idle", 4'b0000, 4'b0000);

    // Time-set back to the target: off, DONE holds while cur==tar, re-arms after it changes.
    cur = 100;
    step(1'b0, "t1 retrig", 4'b0001, 4'b0000);
    off = 1'b1;
    step(1'b0, "t1 off", 4'b0000, 4'b0000);
    off = 1'b0;
    step(1'b0, "t1 done hold", 4'b0000, 4'b0000);
    cur = 101;
    step(1'b0, "t1 done exit", 4'b0000, 4'b0000);
    cur = 100;
    step(1'b0, "t1 rering", 4'b0001, 4'b0000);
    en = 4'b0000;
    step(1'b0, "t5 disable", 4'b0000, 4'b0000);
    step(1'b0, "t5 disabled", 4'b0000, 4'b0000);

    // Snooze three times, fourth snooze ignored, then timeout.
    do_reset();
    set_tar(1, 1000);
    set_len(1, 2'd0);
    en  = 4'b0010;
    cur = 1000;
    step(1'b1, "t2 ring", 4'b0010, 4'b0000);
    step(1'b1, "t2 ring", 4'b0010, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      snooze = 1'b1;
      step(1'b1, "t2 snooze", 4'b0000, 4'b0010);
      snooze = 1'b0;
      for (int k = 0; k < 299; k++) begin
        if (k == 10) snooze = 1'b1;
        step(1'b1, "t2 snoozed", 4'b0000, 4'b0010);
        snooze = 1'b0;
      end
      step(1'b1, "t2 rering", 4'b0010, 4'b0000);
    end
    snooze = 1'b1;
    step(1'b1, "t2 snz limit", 4'b0010, 4'b0000);
    snooze = 1'b0;
    for (int k = 0; k < 14; k++) step(1'b1, "t2 ring on", 4'b0010, 4'b0000);
    step(1'b1, "t2 timeout", 4'b0000, 4'b0000);

    // off and snooze together: off wins for both ringing channels.
    do_reset();
    set_tar(0, 2000);
    set_tar(2, 2000);
    set_len(0, 2'd0);
    set_len(2, 2'd0);
    en  = 4'b0101;
    cur = 1998;
    step(1'b1, "t3 pre", 4'b0000, 4'b0000);
    step(1'b1, "t3 pre", 4'b0000, 4'b0000);
    step(1'b1, "t3 ring", 4'b0101, 4'b0000);
    step(1'b1, "t3 ring", 4'b0101, 4'b0000);
    off    = 1'b1;
    snooze = 1'b1;
    step(1'b1, "t3 off+snz", 4'b0000, 4'b0000);
    off    = 1'b0;
    snooze = 1'b0;
    step(1'b1, "t3 after", 4'b0000, 4'b0000);

    // Midnight wrap: 30 s alarm at 86390 rings 31 edges through 00:00:20.
    do_reset();
    set_tar(2, 86390);
    set_len(2, 2'd1);
    en  = 4'b0100;
    cur = 86388;
    step(1'b1, "t4 pre", 4'b0000, 4'b0000);
    step(1'b1, "t4 pre", 4'b0000, 4'b0000);
    for (int k = 0; k < 31; k++) step(1'b1, "t4 wrap ring", 4'b0100, 4'b0000);
    step(1'b1, "t4 end", 4'b0000, 4'b0000);

    // Reset while snoozed: no re-ring after the snooze interval.
    do_reset();
    set_tar(0, 500);
    set_len(0, 2'd0);
    en  = 4'b0001;
    cur = 500;
    step(1'b1, "t5 ring", 4'b0001, 4'b0000);
    snooze = 1'b1;
    step(1'b1, "t5 snooze", 4'b0000, 4'b0001);
    snooze = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1, "t5 snoozed", 4'b0000, 4'b0001);
    rst = 1'b1;
    step(1'b1, "t5 rst", 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 305; k++) step(1'b1, "t5 no rering", 4'b0000, 4'b0000);

    // active_id priority, global off, same-edge trigger immune to off, out-of-range target.
    do_reset();
    set_tar(3, 2990);
    set_tar(1, 2992);
    set_tar(0, 2994);
    set_tar(2, 90000);
    for (int c = 0; c < N; c++) set_len(c, 2'd0);
    en  = 4'b1111;
    cur = 2990;
    step(1'b1, "t6 ch3", 4'b1000, 4'b0000);
    step(1'b1, "t6 ch3", 4'b1000, 4'b0000);
    step(1'b1, "t6 ch1+3", 4'b1010, 4'b0000);
    step(1'b1, "t6 ch1+3", 4'b1010, 4'b0000);
    off = 1'b1;
    step(1'b1, "t6 off+trig", 4'b0001, 4'b0000);
    off = 1'b0;
    step(1'b1, "t6 ch0", 4'b0001, 4'b0000);
    off = 1'b1;
    step(1'b1, "t6 off ch0", 4'b0000, 4'b0000);
    off = 1'b0;
    cur = 90000;
    step(1'b0, "t6 tar>=day", 4'b0000, 4'b0000);
    step(1'b0, "t6 tar>=day", 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
